// File: rtl/fc_pkg.sv
// Shared state encoding and fixed-point helpers for the streaming fully-connected engine.
// Latency: none (types and pure functions only).
// Backpressure: none (no handshakes here).
package fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_OUT  = 2'd3
    } fc_state_e;

    // Width of the saturation arithmetic; every accumulator must fit inside it.
    localparam int SAT_W = 64;

    // Full product plus enough headroom to sum input_nodes products without wrap.
    function automatic int acc_width(input int data_width, input int input_nodes);
        return 2 * data_width + $clog2(input_nodes);
    endfunction

    // (acc >>> frac_bits) + bias, clamped to the signed data_width range.
    // The arithmetic shift floors toward -inf, dropping fraction bits of the product.
    function automatic logic signed [SAT_W-1:0] sat_to_width(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] bias,
        input int                      frac_bits,
        input int                      data_width
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = (acc >>> frac_bits) + bias;
        hi  = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (data_width - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output lane: signed multiply-accumulate, then bias add, saturate and optional ReLU.
// Latency: accumulator updates on the mac_en edge; res updates on the bias_en edge.
// Backpressure: none locally; the parent gates mac_en/bias_en with its handshakes.
// Ports: clr/mac_en/x/w drive the accumulator; bias_en/b load res; res holds the last result.
// Build option: FC_STREAM_RELU_EN clamps negative results to zero before they are registered.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 39
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clr,
    input  logic                         mac_en,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] w,
    input  logic                         bias_en,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic        [DATA_WIDTH-1:0] res
);

    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic        [DATA_WIDTH-1:0]   res_q, res_d;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic        [DATA_WIDTH-1:0]   res_sat;
    logic        [DATA_WIDTH-1:0]   res_act;

    always_comb begin
        // Operands are sign-extended before multiplying so the full product is exact.
        prod = (2*DATA_WIDTH)'(x) * (2*DATA_WIDTH)'(w);

        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (mac_en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end

        // Saturated value always fits DATA_WIDTH, so truncation keeps the sign.
        res_sat = DATA_WIDTH'(sat_to_width(SAT_W'(acc_q), SAT_W'(b), FRAC_BITS, DATA_WIDTH));
`ifdef FC_STREAM_RELU_EN
        res_act = res_sat[DATA_WIDTH-1] ? '0 : res_sat;
`else
        res_act = res_sat;
`endif

        res_d = res_q;
        if (bias_en) begin
            res_d = res_act;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign res = res_q;

endmodule

// File: rtl/fc_stream_engine.sv
// Streaming fully-connected layer: OUTPUT_NODES signed fixed-point outputs, LANES per group.
// Latency: INPUT_NODES weight beats + 1 bias beat + 1 output beat per group (best case).
// Backpressure: w/b/out are valid-ready; any stall freezes the FSM with outputs held stable.
// Ports: start/in_vec launch a pass; w_* and b_* stream parameters in; out_* stream results;
//        busy covers the pass, done pulses once after the last output handshake.
// Build option: FC_STREAM_RELU_EN applies ReLU to every result (handshake timing unchanged).
module fc_stream_engine
    import fc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int FRAC_BITS    = 8,
    parameter  int INPUT_NODES  = 120,
    parameter  int OUTPUT_NODES = 1200,
    parameter  int LANES        = 4,
    localparam int NUM_GROUPS   = OUTPUT_NODES / LANES,
    localparam int GROUP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [DATA_WIDTH*INPUT_NODES-1:0] in_vec,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [DATA_WIDTH*LANES-1:0]       w_data,
    input  logic                              b_valid,
    output logic                              b_ready,
    input  logic [DATA_WIDTH*LANES-1:0]       b_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH*LANES-1:0]       out_data,
    output logic [GROUP_W-1:0]                out_group,
    output logic                              busy,
    output logic                              done
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, INPUT_NODES);
    localparam int K_W       = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1;

    if (OUTPUT_NODES % LANES != 0) begin : g_bad_lanes
        $error("OUTPUT_NODES must be a multiple of LANES");
    end
    if (ACC_WIDTH > SAT_W) begin : g_bad_acc
        $error("accumulator wider than the saturation datapath");
    end

    fc_state_e                         state_q, state_d;
    logic [K_W-1:0]                    k_q, k_d;
    logic [GROUP_W-1:0]                group_q, group_d;
    logic [DATA_WIDTH*INPUT_NODES-1:0] x_q, x_d;
    logic                              out_valid_q, out_valid_d;
    logic [GROUP_W-1:0]                out_group_q, out_group_d;
    logic                              done_q, done_d;

    logic                  w_hs, b_hs, out_hs, start_acc;
    logic                  last_k, last_group;
    logic                  lane_clr;
    logic [DATA_WIDTH-1:0] x_cur;

    assign w_hs       = w_valid & w_ready;
    assign b_hs       = b_valid & b_ready;
    assign out_hs     = out_valid_q & out_ready;
    assign start_acc  = (state_q == ST_IDLE) & start;
    assign last_k     = (k_q == K_W'(INPUT_NODES - 1));
    assign last_group = (group_q == GROUP_W'(NUM_GROUPS - 1));
    assign x_cur      = x_q[k_q*DATA_WIDTH +: DATA_WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)          state_d = ST_MAC;
            ST_MAC:  if (w_hs && last_k) state_d = ST_BIAS;
            ST_BIAS: if (b_hs)           state_d = ST_OUT;
            ST_OUT:  if (out_hs)         state_d = last_group ? ST_IDLE : ST_MAC;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Moore outputs and lane controls.
    always_comb begin
        w_ready  = (state_q == ST_MAC);
        b_ready  = (state_q == ST_BIAS);
        busy     = (state_q != ST_IDLE);
        // Accumulators start from zero for every group, including the first of a pass.
        lane_clr = start_acc | (out_hs & ~last_group);
    end

    // Counters, input snapshot and output bookkeeping.
    always_comb begin
        k_d         = k_q;
        group_d     = group_q;
        x_d         = x_q;
        out_valid_d = out_valid_q;
        out_group_d = out_group_q;
        done_d      = 1'b0;

        if (start_acc) begin
            x_d     = in_vec;
            k_d     = '0;
            group_d = '0;
        end
        if (w_hs) begin
            k_d = last_k ? '0 : k_q + 1'b1;
        end
        if (b_hs) begin
            out_valid_d = 1'b1;
            out_group_d = group_q;
        end
        if (out_hs) begin
            out_valid_d = 1'b0;
            if (last_group) begin
                done_d = 1'b1;
            end else begin
                group_d = group_q + 1'b1;
                k_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q         <= '0;
            group_q     <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_group_q <= '0;
            done_q      <= 1'b0;
        end else begin
            k_q         <= k_d;
            group_q     <= group_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_group_q <= out_group_d;
            done_q      <= done_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fc_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .clr     (lane_clr),
            .mac_en  (w_hs),
            .x       (x_cur),
            .w       (w_data[l*DATA_WIDTH +: DATA_WIDTH]),
            .bias_en (b_hs),
            .b       (b_data[l*DATA_WIDTH +: DATA_WIDTH]),
            .res     (out_data[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign out_valid = out_valid_q;
    assign out_group = out_group_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fc_stream_engine.sv
// Directed-sequence bench for fc_stream_engine with randomized data and stream gaps.
// Expected results come from an integer dot-product model of the layer.
module tb_fc_stream_engine;

    localparam int DW = 16;
    localparam int FB = 8;
    localparam int IN = 4;
    localparam int ON = 8;
    localparam int LN = 2;
    localparam int NG = ON / LN;
    localparam int GW = 2;
    localparam int TO = 50;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [DW*IN-1:0] in_vec = '0;
    logic             w_valid = 1'b0;
    logic             w_ready;
    logic [DW*LN-1:0] w_data = '0;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [DW*LN-1:0] b_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW*LN-1:0] out_data;
    logic [GW-1:0]    out_group;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic signed [DW-1:0] xs [IN];
    logic signed [DW-1:0] ws [NG][IN][LN];
    logic signed [DW-1:0] bs [NG][LN];

    fc_stream_engine #(
        .DATA_WIDTH   (DW),
        .FRAC_BITS    (FB),
        .INPUT_NODES  (IN),
        .OUTPUT_NODES (ON),
        .LANES        (LN)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .in_vec    (in_vec),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_group (out_group),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Layer output for node g*LN+l: dot product, floor-scale by 2^FB, add bias, clamp.
    function automatic logic [DW-1:0] model(input int g, input int l);
        longint acc = 0;
        longint r;
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        for (int k = 0; k < IN; k++) acc += longint'(xs[k]) * longint'(ws[g][k][l]);
        r = (acc >>> FB) + longint'(bs[g][l]);
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`ifdef FC_STREAM_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] rnd16();
        logic signed [DW-1:0] v;
        v = DW'($urandom);
        return v >>> $urandom_range(0, 7);
    endfunction

    task automatic fill(input int mode);
        for (int k = 0; k < IN; k++) xs[k] = rnd16();
        for (int g = 0; g < NG; g++) begin
            for (int l = 0; l < LN; l++) begin
                bs[g][l] = rnd16();
                for (int k = 0; k < IN; k++) ws[g][k][l] = rnd16();
            end
        end
        if (mode == 0) begin
            xs[0] = 16'sh0100; xs[1] = 16'sh0200; xs[2] = 16'sh0080; xs[3] = 16'shFF00;
            for (int k = 0; k < IN; k++) begin
                ws[0][k][0] = 16'sh0100;
                ws[0][k][1] = 16'shFF00;
            end
            bs[0][0] = 16'sh0040;
            bs[0][1] = 16'sh0000;
        end else if (mode == 1 || mode == 2) begin
            for (int k = 0; k < IN; k++) xs[k] = 16'sh7FFF;
            for (int g = 0; g < NG; g++) begin
                for (int l = 0; l < LN; l++) begin
                    bs[g][l] = 16'sh7FFF;
                    for (int k = 0; k < IN; k++) ws[g][k][l] = (mode == 1) ? 16'sh7FFF : 16'sh8001;
                end
            end
        end
    endtask

    function automatic logic [DW*IN-1:0] pack_x();
        logic [DW*IN-1:0] v;
        for (int k = 0; k < IN; k++) v[k*DW +: DW] = xs[k];
        return v;
    endfunction

    function automatic logic [DW*LN-1:0] pack_w(input int g, input int k);
        logic [DW*LN-1:0] v;
        for (int l = 0; l < LN; l++) v[l*DW +: DW] = ws[g][k][l];
        return v;
    endfunction

    function automatic logic [DW*LN-1:0] pack_b(input int g);
        logic [DW*LN-1:0] v;
        for (int l = 0; l < LN; l++) v[l*DW +: DW] = bs[g][l];
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w_ready"}, w_ready, 0);
        check({tag, "_b_ready"}, b_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_group"}, out_group, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // One layer pass. Called at #1 after a clock edge; returns at #1 after the final
    // output handshake (done cycle), or mid-cycle after an abort reset.
    task automatic run_pass(input int mode, input int wgap, input int bgap,
                            input int stall, input int abort_grp);
        bit               hs;
        int               n;
        int               start_cyc;
        logic [DW*LN-1:0] snap_d;
        logic [GW-1:0]    snap_g;
        logic [DW-1:0]    exp0, exp1;
        fill(mode);
        in_vec = pack_x();
        start  = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        check("start_busy", busy, 1);
        check("done_single_pulse", done, 0);
        in_vec = {$urandom, $urandom};
        for (int g = 0; g < NG; g++) begin
            for (int k = 0; k < IN; k++) begin
                if (g == abort_grp && k == 1) begin
                    w_valid = 1'b0;
                    rstn    = 1'b0;
                    #1;
                    check_reset_outputs("abort");
                    @(negedge clk);
                    rstn = 1'b1;
                    return;
                end
                w_valid = 1'b0;
                repeat ($urandom_range(0, wgap)) begin @(posedge clk); #1; end
                start   = (g == 1 && k == 2);
                in_vec  = {$urandom, $urandom};
                w_valid = 1'b1;
                w_data  = pack_w(g, k);
                check("b_ready_in_mac", b_ready, 0);
                hs = 1'b0;
                n  = 0;
                while (!hs && n < TO) begin
                    hs = w_ready;
                    @(posedge clk); #1;
                    n++;
                end
                check("w_accept", hs, 1);
                if (g == 1 && k == 2) check("busy_start_ignored", busy, 1);
                start = 1'b0;
            end
            // Weight beats offered outside MAC must not be consumed.
            w_valid = 1'b1;
            w_data  = '1;
            check("b_ready_latency", b_ready, 1);
            check("w_ready_in_bias", w_ready, 0);
            repeat ($urandom_range(0, bgap)) begin @(posedge clk); #1; end
            b_valid   = 1'b1;
            b_data    = pack_b(g);
            out_ready = (stall == 0);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < TO) begin
                hs = b_ready;
                @(posedge clk); #1;
                n++;
            end
            check("b_accept", hs, 1);
            b_valid = 1'b0;
            w_valid = 1'b0;
            check("out_valid_latency", out_valid, 1);
            check("out_group", out_group, g);
            for (int l = 0; l < LN; l++) check("out_data_model", out_data[l*DW +: DW], model(g, l));
            if (g == 0 && mode <= 2) begin
`ifdef FC_STREAM_RELU_EN
                exp0 = (mode == 0) ? 16'h02C0 : (mode == 1) ? 16'h7FFF : 16'h0000;
                exp1 = (mode == 1) ? 16'h7FFF : 16'h0000;
`else
                exp0 = (mode == 0) ? 16'h02C0 : (mode == 1) ? 16'h7FFF : 16'h8000;
                exp1 = (mode == 0) ? 16'hFD80 : (mode == 1) ? 16'h7FFF : 16'h8000;
`endif
                check("lane0_directed", out_data[DW-1:0], exp0);
                check("lane1_directed", out_data[2*DW-1:DW], exp1);
            end
            snap_d = out_data;
            snap_g = out_group;
            repeat (stall) begin
                @(posedge clk); #1;
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, snap_d);
                check("stall_group", out_group, snap_g);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (wgap == 0 && bgap == 0 && stall == 0)
                check("group_cycles", cyc - start_cyc, 6 * (g + 1));
            if (g < NG - 1) begin
                check("out_valid_drop", out_valid, 0);
                check("busy_mid_pass", busy, 1);
            end else begin
                check("done_pulse", done, 1);
                check("busy_fall", busy, 0);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        run_pass(0, 0, 0, 0, -1);   // directed example, best-case throughput
        run_pass(1, 0, 0, 0, -1);   // positive saturation, started in the done cycle
        run_pass(2, 0, 0, 0, -1);   // negative saturation
        run_pass(3, 3, 3, 5, -1);   // random data, stream gaps, output stall
        run_pass(3, 0, 0, 0, 2);    // aborted by reset during group 2
        run_pass(3, 2, 2, 1, -1);   // clean pass after the abort
        run_pass(3, 0, 0, 0, -1);

        @(posedge clk); #1;
        check("final_done_low", done, 0);
        check("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_stream_engine.md
Name: fc_stream_engine

Overview:
- Parametrised successor of the first fully-connected layer.
- Computes OUTPUT_NODES outputs from an INPUT_NODES vector, LANES output nodes in parallel, in signed fixed point.
- Weights and biases arrive as valid/ready streams from the parameter loader; results leave as a valid/ready stream to the next layer.
- Replaces the single-node, wide-bus, free-running style with back-pressured streaming, explicit saturation and start/busy/done control.

Parameters:
- DATA_WIDTH, 16: width of activations, weights, biases and outputs (signed two's complement).
- FRAC_BITS, 8: fractional bits of every operand and of the result (Q format).
- INPUT_NODES, 120: input vector length = MAC beats per output group.
- OUTPUT_NODES, 1200: total outputs; must be a multiple of LANES, otherwise elaboration fails.
- LANES, 4: output nodes computed concurrently; NUM_GROUPS = OUTPUT_NODES/LANES.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin a layer pass; honoured only when busy=0.
- in_vec  in  DATA_WIDTH*INPUT_NODES  input activations, element k at [k*DATA_WIDTH +: DATA_WIDTH]; sampled on the accepted start.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat accepted when w_valid & w_ready.
- w_data  in  DATA_WIDTH*LANES  weight for input k, lane l at [l*DATA_WIDTH +: DATA_WIDTH].
- b_valid  in  1  bias beat valid.
- b_ready  out  1  bias beat accepted when b_valid & b_ready.
- b_data  in  DATA_WIDTH*LANES  one bias per lane.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH*LANES  results for nodes group*LANES+l.
- out_group  out  max(1,clog2(NUM_GROUPS))  group index of out_data.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; all outputs 0; accumulators, k and group counters 0. Asserting reset mid-pass aborts the pass; no partial done is issued.
- States:
  - IDLE: start=1 snapshots in_vec, clears accumulators, sets k=0 and group=0, moves to MAC.
  - MAC: w_ready=1. Each handshake does acc[l] += x[k]*w[l] (full 2*DATA_WIDTH product, sign-extended into ACC_WIDTH = 2*DATA_WIDTH + clog2(INPUT_NODES)) and k++. The handshake at k=INPUT_NODES-1 moves to BIAS. While w_valid=0, state holds and nothing changes.
  - BIAS: b_ready=1. On handshake: r[l] = (acc[l] >>> FRAC_BITS) + sign-extended b[l], saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. The arithmetic shift truncates toward -inf. Result is registered into out_data, out_group=group, out_valid=1, move to OUT.
  - OUT: out_data, out_group and out_valid are held stable until out_ready. On handshake, out_valid=0. If group=NUM_GROUPS-1: pulse done, go IDLE. Otherwise group++, k=0, accumulators cleared, go MAC.
- Latency: last weight handshake at cycle T gives b_ready at T+1. Bias handshake at cycle B gives out_valid at B+1.
- Throughput: best case INPUT_NODES+2 cycles per group.
- w_ready=0 outside MAC; b_ready=0 outside BIAS. Beats offered in other states are not consumed.
- start while busy=1 is ignored. start in the done cycle is accepted (state is already IDLE).
- busy deasserts in the same cycle done pulses.
- in_vec changes after start acceptance have no effect on the running pass.

Optional Feature:
- Macro FC_STREAM_RELU_EN.
- Defined: a ReLU is applied after saturation; negative r[l] becomes 0 before registering.
- Undefined: the saturated value is output unchanged.
- Handshake timing is identical in both builds.

Decomposition:
- Package fc_pkg holds:
  - state enum (IDLE, MAC, BIAS, OUT);
  - ACC_WIDTH derivation function;
  - sat_to_width function (accumulator + bias -> DATA_WIDTH with saturation).
- Sub-module fc_mac_lane: one lane's accumulator with clear, MAC-enable and bias/saturate/ReLU output. It is instantiated LANES times by generate.
- Top level keeps the FSM, counters, in_vec snapshot and handshakes.

Test Plan:
- Config DATA_WIDTH=16, FRAC_BITS=8, INPUT_NODES=4, OUTPUT_NODES=8, LANES=2.
  - x={0x0100,0x0200,0x0080,0xFF00}; lane0 weights all 0x0100, bias 0x0040; lane1 weights all 0xFF00, bias 0 -> group0 out_data lane0=0x02C0, lane1=0xFD80 (0x0000 with FC_STREAM_RELU_EN). 4 groups emitted, then done pulses once and busy falls.
- Saturation: x all 0x7FFF, weights all 0x7FFF, bias 0x7FFF -> 0x7FFF. Weights all 0x8001 -> 0x8000, or 0x0000 with ReLU.
- Back-pressure: random gaps on w_valid and b_valid, out_ready low for 5 cycles -> out_data and out_group stable while stalled, results identical to the no-stall run, no beat lost or duplicated.
- Control: start pulsed while busy -> ignored. start in the done cycle -> second pass begins with freshly sampled in_vec. in_vec changed mid-pass -> no effect on results.
- Reset mid-MAC of group 2 -> all outputs 0 immediately. A new start after release produces a complete, correct pass from group 0.
- Back-to-back groups with always-valid streams and out_ready=1 -> exactly INPUT_NODES+2 = 6 cycles per group.
